// File: rtl/cpm_skid_reg.sv
// cpm_skid_reg: two-entry valid/ready register slice for the CPM datapath.
// Data moves forward and ready moves backward through flops, so long
// PE-to-buffer paths can be cut without a combinational ready chain.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_EMPTY | no word held; o_in_rdy high, o_out_vld low
// ST_ONE   | main register holds the head word; skid register unused
// ST_FULL  | main holds the head word, skid holds the next word
module cpm_skid_reg #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_in_vld,
    output logic          o_in_rdy,
    input  logic [DW-1:0] i_in_data,
    output logic          o_out_vld,
    input  logic          i_out_rdy,
    output logic [DW-1:0] o_out_data,
    output logic [1:0]    o_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_main;
    logic [DW-1:0]   r_skid;
    logic [1:0]      r_cnt;

    logic            w_in_rdy;
    logic            w_out_vld;
    logic            w_push;
    logic            w_pop;

    // Handshake qualifiers come from registered state only; Clr is the one
    // input allowed to gate them combinationally so a flush cycle never
    // completes a transfer.
    assign w_in_rdy  = (r_state != ST_FULL) & ~i_clr;
    assign w_out_vld = (r_state != ST_EMPTY) & ~i_clr;
    assign w_push    = i_in_vld & w_in_rdy;
    assign w_pop     = w_out_vld & i_out_rdy;

    assign o_in_rdy   = w_in_rdy;
    assign o_out_vld  = w_out_vld;
    assign o_out_data = r_main;
    assign o_cnt      = r_cnt;

    // Slice state machine: occupancy, main/skid storage and registered count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_cnt   <= 2'd0;
        end else if (i_clr) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_cnt   <= 2'd0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_main  <= i_in_data;
                        r_state <= ST_ONE;
                        r_cnt   <= 2'd1;
                    end
                end
                ST_ONE: begin
                    if (w_push && !w_pop) begin
                        r_skid  <= i_in_data;
                        r_state <= ST_FULL;
                        r_cnt   <= 2'd2;
                    end else if (w_pop && !w_push) begin
                        // main keeps its stale value; OutVld masks it
                        r_state <= ST_EMPTY;
                        r_cnt   <= 2'd0;
                    end else if (w_push && w_pop) begin
                        r_main  <= i_in_data;
                    end
                end
                ST_FULL: begin
                    // InRdy is low here, so only a pop can happen
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                        r_cnt   <= 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_cnt   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/cpm_skid_reg.md
# cpm_skid_reg

Two-entry valid/ready register slice for the CPM datapath of the systolic array. Unlike the free-running pipeline register, it carries backpressure upstream. Data moves forward and ready moves backward, each through flops, so long PE-to-buffer paths can be cut without a combinational ready chain. It sustains one transfer per cycle and loses no data when the consumer stalls.

## Interface
- DW, 8, data width in bits.
- Clk  input  1  single clock, rising edge.
- Rstn  input  1  reset, asynchronous, active-low.
- Clr  input  1  synchronous flush, active-high, highest priority after reset.
- InVld  input  1  upstream data valid.
- InRdy  output  1  slice can accept; derived from registered state and Clr only, never from OutRdy.
- InData  input  DW  upstream data.
- OutVld  output  1  OutData valid.
- OutRdy  input  1  downstream can accept.
- OutData  output  DW  head-of-slice data, driven directly from a register.
- Cnt  output  2  occupancy, 0..2.

## Operation
- Handshakes:
  - push = InVld & InRdy.
  - pop = OutVld & OutRdy.
  - A transfer occurs only on a rising Clk edge with both signals high.
- Storage: main register (drives OutData) and skid register (holds the overflow word).
- States: EMPTY (Cnt=0), ONE (Cnt=1), FULL (Cnt=2).
- Outputs from state:
  - InRdy = (state != FULL) & ~Clr.
  - OutVld = (state != EMPTY) & ~Clr.
- EMPTY:
  - push: main <= InData, go to ONE.
  - Otherwise stay; no pop is possible.
- ONE:
  - push & ~pop: skid <= InData, go to FULL.
  - pop & ~push: go to EMPTY; main keeps its stale value.
  - push & pop: main <= InData, stay in ONE.
  - Neither: hold.
- FULL:
  - InRdy = 0, so no push occurs.
  - pop: main <= skid, go to ONE.
  - No pop: hold both registers.
- Ordering is strictly FIFO: the skid word always leaves after the main word.
- Clr = 1:
  - Next state is EMPTY; main and skid are cleared to 0.
  - InRdy and OutVld are low in that cycle, so no transfer happens; InVld/OutRdy are don't-care.
- Data is passed bit-exact with no width change; DW ≥ 1.
- InData is sampled only on push. OutData is meaningful only while OutVld = 1.

## Timing
- Rstn low, asynchronously and with immediate effect:
  - state = EMPTY, main = 0, skid = 0.
  - Outputs: OutVld = 0, OutData = 0, Cnt = 0, InRdy = 1 (when Clr = 0).
- Reset mid-operation: all stored words are discarded with no partial transfer. The first push is allowed on the first rising edge after Rstn deasserts.
- Latency: a word pushed at edge N is visible on OutData with OutVld = 1 after edge N, i.e. one cycle.
- Throughput: with OutRdy held high, one word per cycle indefinitely and Cnt stays ≤ 1.
- Stall: when OutRdy drops, the slice absorbs exactly one extra word, then InRdy goes low the cycle after reaching FULL.
- Release from FULL: OutRdy high drains one word per cycle. InRdy returns high the cycle after the first pop.
- Combinational paths: none from OutRdy to InRdy, and none from InVld/InData to OutVld/OutData. Clr feeds InRdy/OutVld combinationally by design.

## Test plan
- Reset: hold Rstn low with random inputs. Require OutVld = 0, OutData = 0, Cnt = 0, InRdy = 1. Release Rstn, push 0x5A; next cycle require OutVld = 1, OutData = 0x5A, Cnt = 1.
- Streaming: OutRdy = 1, push 0x01..0x20 on consecutive cycles. Require output 0x01..0x20 in order, each one cycle after input, with no bubbles and Cnt ≤ 1.
- Stall and skid:
  - Push 0xA1, then 0xA2 with OutRdy = 0. Require Cnt = 2, InRdy = 0, OutData = 0xA1.
  - Hold 3 cycles with InVld = 1 and InData = 0xA3. Require no acceptance.
  - Raise OutRdy. Require output 0xA1, 0xA2, 0xA3 in that order.
- Simultaneous push/pop in ONE: main = 0x10, push 0x11 with OutRdy = 1. Require Cnt stays 1 and OutData = 0x11 the next cycle.
- Flush: fill to FULL (0x33, 0x44) and assert Clr for one cycle with InVld = OutRdy = 1. Require InRdy = OutVld = 0 that cycle, then Cnt = 0 and OutData = 0, with neither word ever popped.
- Random: random InVld/OutRdy over 10k cycles against a queue scoreboard. Require no loss, no duplication, in-order delivery, and Cnt equal to the model occupancy every cycle.
